// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency memory between instruction fetch and data access.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is data-priority with fetch starvation relief.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_imem_req_valid,
    output logic                io_imem_req_ready,
    input  logic [ADDR_W-1:0]   io_imem_addr,
    output logic                io_imem_resp_valid,
    output logic [DATA_W-1:0]   io_imem_rdata,
    input  logic                io_dmem_req_valid,
    output logic                io_dmem_req_ready,
    input  logic [ADDR_W-1:0]   io_dmem_addr,
    input  logic                io_dmem_wen,
    input  logic [DATA_W-1:0]   io_dmem_wdata,
    input  logic [DATA_W/8-1:0] io_dmem_wmask,
    output logic                io_dmem_resp_valid,
    output logic [DATA_W-1:0]   io_dmem_rdata,
    output logic                io_mem_en,
    output logic                io_mem_wen,
    output logic [ADDR_W-1:0]   io_mem_addr,
    output logic [DATA_W-1:0]   io_mem_wdata,
    output logic [DATA_W/8-1:0] io_mem_wmask,
    input  logic [DATA_W-1:0]   io_mem_rdata,
    output logic [15:0]         io_conflicts
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic        was_write_q, was_write_d;
    logic [15:0] conflicts_q, conflicts_d;
    logic        gnt_imem, gnt_dmem, contested;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        rr_imem_next_q, rr_imem_next_d;
`else
    logic [3:0]  starve_q, starve_d;
`endif

    assign contested = io_imem_req_valid && io_dmem_req_valid;

    // Grant is suppressed while reset is high so nothing reaches the memory.
    always_comb begin
        gnt_imem = 1'b0;
        gnt_dmem = 1'b0;
        if (!reset) begin
            if (contested) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gnt_imem = rr_imem_next_q;
`else
                gnt_imem = (starve_q >= 4'(STARVE_LIMIT));
`endif
                gnt_dmem = !gnt_imem;
            end else begin
                gnt_imem = io_imem_req_valid;
                gnt_dmem = io_dmem_req_valid;
            end
        end
    end

    always_comb begin
        io_imem_req_ready = gnt_imem;
        io_dmem_req_ready = gnt_dmem;
        io_mem_en         = gnt_imem || gnt_dmem;
        io_mem_wen        = gnt_dmem && io_dmem_wen;
        io_mem_addr       = '0;
        io_mem_wdata      = '0;
        io_mem_wmask      = '0;
        if (gnt_imem) begin
            io_mem_addr = io_imem_addr;
        end else if (gnt_dmem) begin
            io_mem_addr  = io_dmem_addr;
            io_mem_wdata = io_dmem_wdata;
            io_mem_wmask = io_dmem_wmask;
        end
    end

    always_comb begin
        owner_d     = OWN_NONE;
        was_write_d = gnt_dmem && io_dmem_wen;
        conflicts_d = conflicts_q;
        if (gnt_imem) begin
            owner_d = OWN_IMEM;
        end else if (gnt_dmem) begin
            owner_d = OWN_DMEM;
        end
        if (contested && (conflicts_q != 16'hFFFF)) begin
            conflicts_d = conflicts_q + 16'd1;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_imem_next_d = contested ? gnt_dmem : rr_imem_next_q;
`else
        starve_d = 4'd0;
        if (io_imem_req_valid && !gnt_imem) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q        <= OWN_NONE;
            was_write_q    <= 1'b0;
            conflicts_q    <= 16'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_imem_next_q <= 1'b1;
`else
            starve_q       <= 4'd0;
`endif
        end else begin
            owner_q        <= owner_d;
            was_write_q    <= was_write_d;
            conflicts_q    <= conflicts_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_imem_next_q <= rr_imem_next_d;
`else
            starve_q       <= starve_d;
`endif
        end
    end

    // Responses are masked during reset so a response pending at reset is dropped.
    always_comb begin
        io_imem_resp_valid = !reset && (owner_q == OWN_IMEM);
        io_dmem_resp_valid = !reset && (owner_q == OWN_DMEM);
        io_imem_rdata      = io_imem_resp_valid ? io_mem_rdata : '0;
        io_dmem_rdata      = (io_dmem_resp_valid && !was_write_q) ? io_mem_rdata : '0;
        io_conflicts       = conflicts_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int SL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_v, d_v, d_w;
    logic [AW-1:0] i_a, d_a;
    logic [DW-1:0] d_wd, m_rd;
    logic [MW-1:0] d_wm;

    logic          io_imem_req_ready, io_imem_resp_valid;
    logic [DW-1:0] io_imem_rdata;
    logic          io_dmem_req_ready, io_dmem_resp_valid;
    logic [DW-1:0] io_dmem_rdata;
    logic          io_mem_en, io_mem_wen;
    logic [AW-1:0] io_mem_addr;
    logic [DW-1:0] io_mem_wdata;
    logic [MW-1:0] io_mem_wmask;
    logic [15:0]   io_conflicts;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state: owner 0 = none, 1 = fetch, 2 = data.
    int m_owner = 0;
    int m_was_write = 0;
    int m_starve = 0;
    int m_rr_imem = 1;
    int m_conf = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (i_v),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_addr       (i_a),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_rdata      (io_imem_rdata),
        .io_dmem_req_valid  (d_v),
        .io_dmem_req_ready  (io_dmem_req_ready),
        .io_dmem_addr       (d_a),
        .io_dmem_wen        (d_w),
        .io_dmem_wdata      (d_wd),
        .io_dmem_wmask      (d_wm),
        .io_dmem_resp_valid (io_dmem_resp_valid),
        .io_dmem_rdata      (io_dmem_rdata),
        .io_mem_en          (io_mem_en),
        .io_mem_wen         (io_mem_wen),
        .io_mem_addr        (io_mem_addr),
        .io_mem_wdata       (io_mem_wdata),
        .io_mem_wmask       (io_mem_wmask),
        .io_mem_rdata       (m_rd),
        .io_conflicts       (io_conflicts)
    );

    function automatic int predict_winner(input logic rst, input logic iv, input logic dv);
        if (rst) return 0;
        if (iv && dv) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (m_rr_imem != 0) ? 1 : 2;
`else
            return (m_starve >= SL) ? 1 : 2;
`endif
        end
        if (iv) return 1;
        if (dv) return 2;
        return 0;
    endfunction

    task automatic model_step();
        int w;
        w = predict_winner(reset, i_v, d_v);
        if (reset) begin
            m_owner = 0; m_was_write = 0; m_starve = 0; m_rr_imem = 1; m_conf = 0;
        end else begin
            m_owner     = w;
            m_was_write = (w == 2 && d_w) ? 1 : 0;
            if (i_v && d_v) begin
                m_conf    = (m_conf < 65535) ? m_conf + 1 : 65535;
                m_rr_imem = (w == 2) ? 1 : 0;
            end
            if (i_v && w != 1) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else               m_starve = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        i_v = 1'b0; i_a = '0; d_v = 1'b0; d_a = '0; d_w = 1'b0; d_wd = '0; d_wm = '0;
        m_rd = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; drive_idle(); i_v = 1'b1; d_v = 1'b1;
        #1;
        vectors++;
        if ({io_imem_req_ready, io_dmem_req_ready, io_mem_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_cycle_grant: got %b expected 000", {io_imem_req_ready, io_dmem_req_ready, io_mem_en});
        end
        tick();
        reset = 1'b0; drive_idle(); m_rd = 32'hA5A5_5A5A;
        #1;
        vectors++;
        if ({io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata, io_conflicts} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got ivld=%b dvld=%b ird=%h drd=%h conf=%h expected all 0",
                     io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata, io_conflicts);
        end
        tick();
    endtask

    task automatic test_fetch_only();
        drive_idle(); i_v = 1'b1; i_a = 32'h10;
        #1;
        vectors++;
        if ({io_imem_req_ready, io_dmem_req_ready, io_mem_en, io_mem_wen, io_mem_addr} !== {4'b1010, 32'h10}) begin
            miscompares++;
            $display("FAIL fetch_grant: got ir=%b dr=%b en=%b wen=%b addr=%h expected 1 0 1 0 00000010",
                     io_imem_req_ready, io_dmem_req_ready, io_mem_en, io_mem_wen, io_mem_addr);
        end
        tick();
        drive_idle(); m_rd = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({io_imem_resp_valid, io_imem_rdata, io_dmem_resp_valid, io_dmem_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL fetch_resp: got ivld=%b ird=%h dvld=%b drd=%h expected 1 deadbeef 0 0",
                     io_imem_resp_valid, io_imem_rdata, io_dmem_resp_valid, io_dmem_rdata);
        end
        tick();
    endtask

    task automatic test_store();
        drive_idle(); d_v = 1'b1; d_w = 1'b1; d_a = 32'h40; d_wd = 32'h12345678; d_wm = 4'hF;
        #1;
        vectors++;
        if ({io_dmem_req_ready, io_imem_req_ready, io_mem_en, io_mem_wen, io_mem_addr, io_mem_wdata, io_mem_wmask}
            !== {4'b1011, 32'h40, 32'h12345678, 4'hF}) begin
            miscompares++;
            $display("FAIL store_grant: got dr=%b ir=%b en=%b wen=%b addr=%h wd=%h wm=%h expected 1 0 1 1 00000040 12345678 f",
                     io_dmem_req_ready, io_imem_req_ready, io_mem_en, io_mem_wen, io_mem_addr, io_mem_wdata, io_mem_wmask);
        end
        tick();
        drive_idle(); m_rd = 32'h7777_8888;
        #1;
        vectors++;
        if ({io_dmem_resp_valid, io_dmem_rdata, io_imem_resp_valid, io_imem_rdata} !== {1'b1, 32'h0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL store_ack: got dvld=%b drd=%h ivld=%b ird=%h expected 1 0 0 0",
                     io_dmem_resp_valid, io_dmem_rdata, io_imem_resp_valid, io_imem_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        reset = 1'b1; drive_idle(); tick();
        reset = 1'b0; drive_idle(); i_v = 1'b1; i_a = 32'h100; d_v = 1'b1; d_a = 32'h200;
        for (int k = 0; k < 10; k++) begin
            #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
            vectors++;
            if ({io_imem_req_ready, io_dmem_req_ready} !== exp_g) begin
                miscompares++;
                $display("FAIL contention_seq[%0d]: got ir,dr=%b expected %b", k, {io_imem_req_ready, io_dmem_req_ready}, exp_g);
            end
            tick();
        end
        drive_idle();
        #1;
        vectors++;
        if (io_conflicts !== 16'd10) begin
            miscompares++;
            $display("FAIL contention_count: got %0d expected 10", io_conflicts);
        end
        tick();
    endtask

    task automatic test_reset_after_grant();
        drive_idle(); d_v = 1'b1; d_a = 32'h80;
        #1;
        vectors++;
        if (io_dmem_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_load_grant: got dr=%b expected 1", io_dmem_req_ready);
        end
        tick();
        reset = 1'b1; drive_idle(); m_rd = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if ({io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_drop_resp: got ivld=%b dvld=%b ird=%h drd=%h expected all 0",
                     io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata);
        end
        tick();
        reset = 1'b0; drive_idle(); m_rd = 32'h1234_ABCD;
        #1;
        vectors++;
        if ({io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata, io_conflicts,
             io_imem_req_ready, io_dmem_req_ready, io_mem_en} !== '0) begin
            miscompares++;
            $display("FAIL rst_after: got ivld=%b dvld=%b ird=%h drd=%h conf=%h ir=%b dr=%b en=%b expected all 0",
                     io_imem_resp_valid, io_dmem_resp_valid, io_imem_rdata, io_dmem_rdata, io_conflicts,
                     io_imem_req_ready, io_dmem_req_ready, io_mem_en);
        end
        tick();
    endtask

    task automatic test_random();
        logic i_free, d_free;
        int w;
        logic [86:0] exp_v, got_v;
        i_free = 1'b1; d_free = 1'b1;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (i_free) begin i_v = ($urandom_range(0, 3) != 0); i_a = $urandom; end
            if (d_free) begin
                d_v = ($urandom_range(0, 3) != 0); d_a = $urandom; d_w = $urandom_range(0, 1);
                d_wd = $urandom; d_wm = 4'($urandom);
            end
            m_rd = $urandom;
            #1;
            w = predict_winner(reset, i_v, d_v);
            exp_v = {(w == 1), (w == 2), (w != 0), (w == 2 && d_w),
                     (!reset && m_owner == 1), (!reset && m_owner == 1) ? m_rd : 32'h0,
                     (!reset && m_owner == 2), (!reset && m_owner == 2 && m_was_write == 0) ? m_rd : 32'h0,
                     m_conf[15:0]};
            got_v = {io_imem_req_ready, io_dmem_req_ready, io_mem_en, io_mem_wen,
                     io_imem_resp_valid, io_imem_rdata, io_dmem_resp_valid, io_dmem_rdata, io_conflicts};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got %h expected %h (ir,dr,en,wen,ivld,ird,dvld,drd,conf)", n, got_v, exp_v);
            end
            if (w != 0) begin
                vectors++;
                if (io_mem_addr !== ((w == 1) ? i_a : d_a)) begin
                    miscompares++;
                    $display("FAIL rand_addr[%0d]: got %h expected %h", n, io_mem_addr, (w == 1) ? i_a : d_a);
                end
            end
            if (w == 2) begin
                vectors++;
                if ({io_mem_wdata, io_mem_wmask} !== {d_wd, d_wm}) begin
                    miscompares++;
                    $display("FAIL rand_wdata[%0d]: got %h/%h expected %h/%h", n, io_mem_wdata, io_mem_wmask, d_wd, d_wm);
                end
            end
            i_free = reset || !i_v || (w == 1);
            d_free = reset || !d_v || (w == 2);
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_conflict_saturation();
        reset = 1'b1; drive_idle(); tick();
        reset = 1'b0; drive_idle(); i_v = 1'b1; d_v = 1'b1; i_a = 32'h4; d_a = 32'h8;
        repeat (65540) tick();
        vectors++;
        if (io_conflicts !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL conflict_sat: got %h expected ffff", io_conflicts);
        end
        tick();
        vectors++;
        if (io_conflicts !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL conflict_hold: got %h expected ffff", io_conflicts);
        end
        drive_idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        @(posedge clock);
        #1;
        test_reset();
        test_fetch_only();
        test_store();
        test_contention();
        test_reset_after_grant();
        test_random();
        test_conflict_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
